// File: rtl/cnn_pkg.sv
// Shared constants, datapath types and FSM encoding for the convolution MAC engine.
package cnn_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAC_W    = 8;
  localparam int unsigned ACC_W     = 40;
  localparam int unsigned TAPS      = 25;
  localparam int unsigned POSITIONS = 144;

  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned POS_W = $clog2(POSITIONS);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FINISH,
    OUT,
    DONE
  } mac_state_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: signed accumulator plus round / bias / ReLU / saturate into a result register.
module mac_lane
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              acc_en,
  input  logic              finish,
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  localparam acc_t RoundHalf = acc_t'(1) <<< (FRAC_W - 1);
  localparam acc_t SatMax    = acc_t'((1 << (DATA_W - 1)) - 1);

  logic signed [2*DATA_W-1:0] prod;
  acc_t  acc_q, acc_d;
  acc_t  rounded, summed;
  data_t result_q, result_d;

  always_comb begin
    prod = (2*DATA_W)'($signed(pix)) * (2*DATA_W)'($signed(weight));

    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + acc_t'(prod);
    end

    // Round half up, then add bias before clamping to the non-negative data range.
    rounded = (acc_q + RoundHalf) >>> FRAC_W;
    summed  = rounded + acc_t'($signed(bias));
    if (summed < 0) begin
      result_d = '0;
    end else if (summed > SatMax) begin
      result_d = data_t'(SatMax);
    end else begin
      result_d = data_t'(summed);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (finish) begin
        result_q <= result_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: rtl/conv_mac_engine.sv
// Four-lane convolution MAC engine: tap/position sequencing FSM driving four mac_lane datapaths.
module conv_mac_engine
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pix0,
  input  logic [DATA_W-1:0] pix1,
  input  logic [DATA_W-1:0] pix2,
  input  logic [DATA_W-1:0] pix3,
  input  logic [DATA_W-1:0] weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              busy,
  output logic              done
);

  mac_state_t        state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [DATA_W-1:0] bias_q, bias_d;

  logic lane_clear, acc_en, finish, out_hs;

  logic [DATA_W-1:0] lane_pix    [4];
  logic [DATA_W-1:0] lane_result [4];

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    pos_d      = pos_q;
    bias_d     = bias_q;
    lane_clear = 1'b0;

    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    acc_en    = in_ready & in_valid;
    finish    = (state_q == FINISH);
    out_hs    = out_valid & out_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          bias_d     = bias;
          tap_d      = '0;
          pos_d      = '0;
          lane_clear = 1'b1;
        end
      end
      ACCUM: begin
        if (acc_en) begin
          if (tap_q == TAP_W'(TAPS - 1)) begin
            state_d = FINISH;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      FINISH: state_d = OUT;
      OUT: begin
        if (out_hs) begin
          lane_clear = 1'b1;
          tap_d      = '0;
          if (pos_q == POS_W'(POSITIONS - 1)) begin
            state_d = DONE;
          end else begin
            pos_d   = pos_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      pos_q   <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      pos_q   <= pos_d;
      bias_q  <= bias_d;
    end
  end

  assign lane_pix = '{pix0, pix1, pix2, pix3};

  for (genvar l = 0; l < 4; l++) begin : g_lane
    mac_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .clear  (lane_clear),
      .acc_en (acc_en),
      .finish (finish),
      .pix    (lane_pix[l]),
      .weight (weight),
      .bias   (bias_q),
      .result (lane_result[l])
    );
  end

  assign out_data0 = lane_result[0];
  assign out_data1 = lane_result[1];
  assign out_data2 = lane_result[2];
  assign out_data3 = lane_result[3];

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Four-lane multiply-accumulate engine for the convolution stage. It consumes the pixel and weight streams fetched through the image-read and kernel-read address counters, one kernel tap per beat with four image positions in parallel. It accumulates 25 taps per output pixel, then applies bias, rounding, ReLU and saturation. Results are presented to the conv output write counter through a valid/ready handshake.

## Interface
- `DATA_W`, 16: signed fixed-point width of pixels, weights, bias and outputs.
- `FRAC_W`, 8: fractional bits of every `DATA_W` quantity.
- `ACC_W`, 40: accumulator width; must be ≥ 2·`DATA_W`+5.
- `TAPS`, 25: kernel taps per output pixel.
- `POSITIONS`, 144: output pixels per lane per run (24·24/4).
- `clk` in 1: the single clock.
- `reset` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse that begins a run; honoured only in IDLE.
- `bias` in `DATA_W`: sampled on the accepted `start`.
- `in_valid` in 1: pixel/weight beat valid.
- `in_ready` out 1: engine accepts a beat.
- `pix0`..`pix3` in `DATA_W` each: lane pixels for the current tap.
- `weight` in `DATA_W`: kernel tap shared by all lanes.
- `out_valid` out 1: `out_data0..3` hold one finished output pixel per lane.
- `out_ready` in 1: consumer accepts outputs.
- `out_data0`..`out_data3` out `DATA_W` each: results.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when the run completes.

## Operation
- States: IDLE, ACCUM, FINISH, OUT, DONE.
- IDLE: `start` → ACCUM. `bias` is latched, and the accumulators, tap counter and position counter are cleared. `in_valid` is ignored.
- ACCUM: `in_ready`=1. A beat is accepted when `in_valid`&`in_ready`.
  - On each accepted beat, every lane adds `pix_i`·`weight` (signed, full 2·`DATA_W` product, sign-extended to `ACC_W`) into its accumulator.
  - The tap counter runs 0..`TAPS`-1. Acceptance of tap `TAPS`-1 → FINISH.
- FINISH (1 cycle): per lane, compute
  - r = (acc + 2^(`FRAC_W`-1)) >>> `FRAC_W` (arithmetic shift, round half up), then
  - s = r + sign-extended bias,
  - then clamp: s<0 → 0; s>2^(`DATA_W`-1)-1 → 2^(`DATA_W`-1)-1.
  - The clamped value is registered into `out_data_i`. → OUT.
- OUT: `out_valid`=1, `in_ready`=0.
  - On `out_valid`&`out_ready`: the position counter increments, and the accumulators and tap counter clear.
  - If this was position `POSITIONS`-1 → DONE, else → ACCUM.
- DONE (1 cycle): `done`=1 → IDLE.
- `start` outside IDLE is ignored. `in_valid` outside ACCUM is ignored and never counted.
- `reset` at any cycle → IDLE and all counters, accumulators and outputs cleared. It takes priority over every other input that cycle.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `done`=0, `out_data0..3`=0.
- `in_ready` rises in the cycle after `start` is sampled.
- Last tap accepted at edge k → FINISH during cycle k..k+1 → `out_valid` high after edge k+1. Result latency is 2 edges from the final beat.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `out_ready` held high: OUT lasts exactly 1 cycle; ACCUM resumes the next cycle. This gives a minimum of `TAPS`+2 cycles per position.
- `done` is asserted exactly once per run, one cycle after the final output handshake. `busy` drops in the cycle after `done`.

## Structure
- Package `cnn_pkg` holds:
  - constants `DATA_W`, `FRAC_W`, `ACC_W`, `TAPS`, `POSITIONS`;
  - typedef `data_t` (signed `DATA_W`) and `acc_t` (signed `ACC_W`);
  - enum `mac_state_t` {IDLE, ACCUM, FINISH, OUT, DONE}.
- Sub-module `mac_lane` holds one accumulator and the round/bias/ReLU/saturate datapath, with inputs `clear`, `acc_en`, `finish`. It is instantiated four times; the FSM and counters live in the top.

## Test plan
- All-ones product: pix=0x0100 (1.0), weight=0x0100, bias=0, 25 back-to-back beats → `out_data0..3`=0x1900 (25.0), `out_valid` 2 edges after the last beat.
- ReLU: pix=0x0100, weight=0xFF00 (-1.0), bias=0x0200 → r=-25+2<0 → all outputs 0x0000.
- Saturation: pix=weight=0x7FFF for 25 beats, bias=0x7FFF → all outputs 0x7FFF.
- Rounding: pix=0x0001, weight=0x0080 for 25 beats → acc=3200 → (3200+128)>>>8=13 → 0x000D.
- Stalls: random `in_valid` gaps plus `out_ready` low for 5 cycles →
  - only handshaken beats counted,
  - `in_ready`=0 during OUT,
  - `out_data` stable through the stall,
  - results identical to the no-stall run.
- Full run with `POSITIONS`=144: `done` is a single pulse after the 144th output handshake. Then reset asserted mid-ACCUM at tap 10 of a second run →
  - all outputs 0 and `busy`=0 next cycle,
  - a fresh `start` yields 0x1900 for the all-ones stimulus.
